// File: rtl/add_seq_ctrl.sv
// Sequencer that builds a WIDE-bit add out of one external SLICE_W-bit adder slice,
// feeding one slice per cycle (LSB first) and rippling the carry through a register.
module add_seq_ctrl #(
    parameter int SLICE_W = 4,
    parameter int NSLICES = 4,
    localparam int WIDE = SLICE_W * NSLICES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clr,
    input  logic [WIDE-1:0]    a,
    input  logic [WIDE-1:0]    b,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [WIDE-1:0]    sum,
    output logic               cout,
    output logic               ovf,
    output logic [SLICE_W-1:0] slc_x,
    output logic [SLICE_W-1:0] slc_y,
    output logic               slc_ci,
    input  logic [SLICE_W-1:0] slc_s,
    input  logic               slc_co
);

    localparam int IDX_W = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDE-1:0]  a_l;
    logic [WIDE-1:0]  b_l;

    // Handshake: a request is taken on any edge where start=1, clr=0 and the
    // sequencer is idle (busy=0); requests while busy are dropped, not queued.
    // done pulses for exactly one cycle with sum/cout/ovf valid, and a new
    // request may be taken in that same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_l   <= '0;
            b_l   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                state <= IDLE;
                idx   <= '0;
                sum   <= '0;
                cout  <= 1'b0;
                ovf   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= RUN;
                            a_l   <= a;
                            b_l   <= b;
                            carry <= cin;
                            idx   <= '0;
                            cout  <= 1'b0;
                            ovf   <= 1'b0;
                        end
                    end
                    RUN: begin
                        sum[idx*SLICE_W +: SLICE_W] <= slc_s;
                        carry <= slc_co;
                        if (idx == LAST_IDX) begin
                            // Top slice's sum MSB is the result sign bit.
                            state <= IDLE;
                            idx   <= '0;
                            cout  <= slc_co;
                            done  <= 1'b1;
                            ovf   <= (a_l[WIDE-1] == b_l[WIDE-1]) &&
                                     (slc_s[SLICE_W-1] != a_l[WIDE-1]);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state == RUN);

    always_comb begin
        slc_x  = '0;
        slc_y  = '0;
        slc_ci = 1'b0;
        if (state == RUN) begin
            slc_x  = a_l[idx*SLICE_W +: SLICE_W];
            slc_y  = b_l[idx*SLICE_W +: SLICE_W];
            slc_ci = carry;
        end
    end

endmodule
